mem_request_arbiter: RTL and testbench

- Parametrised successor to the single-port request unit. Sits between the RISC-V datapath and the memory controller.
- Arbitrates instruction-fetch and data requests onto one memory port, data first. Latches each accepted request.
- Generates byte enables and load sign/zero extension from the fetch size. Flags misaligned accesses.
- Aborts any access the controller does not complete within a bounded number of cycles.

---
 rtl/cpu_types_pkg.sv | 34 +++
 rtl/lane_align.sv | 51 +++++
 rtl/mem_request_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_request_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the datapath-to-memory request path: fetch codes, arbiter states, byte offsets.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package cpu_types_pkg;

    // Size/sign code carried with every data access
    typedef enum logic [2:0] {
        FC_LB  = 3'b000,
        FC_LH  = 3'b001,
        FC_LW  = 3'b010,
        FC_LBU = 3'b100,
        FC_LHU = 3'b101
    } fetch_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DACC = 2'd1,
        ST_IACC = 2'd2
    } arb_state_e;

    // Byte position inside a 32-bit word; alignment rules are stated on these two bits
    typedef logic [1:0] byte_off_t;

    // True when the code is not a legal size, or the address is not aligned to that size
    function automatic logic access_bad(input logic [2:0] code, input byte_off_t off);
        case (code)
            FC_LB, FC_LBU: return 1'b0;
            FC_LH, FC_LHU: return off[0];
            FC_LW:         return off != 2'b00;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: byte enables and store shift for a request, shift plus extend for a load.
// Latency: purely combinational.
// Backpressure: none; the caller registers every result.
module lane_align
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                      req_size,
    input  logic [$clog2(DATA_W/8)-1:0]     req_off,
    input  logic                            req_store,
    input  logic [DATA_W-1:0]               req_store_dat,
    output logic [DATA_W/8-1:0]             be,
    output logic [DATA_W-1:0]               store_lane,
    input  logic [2:0]                      ld_code,
    input  logic [$clog2(DATA_W/8)-1:0]     ld_off,
    input  logic [DATA_W-1:0]               ld_raw,
    output logic [DATA_W-1:0]               ld_ext
);
    localparam int NB = DATA_W / 8;

    logic [NB-1:0]     size_be;
    logic [DATA_W-1:0] ld_shift;

    // Byte enables: sized mask at the byte offset for stores, every lane on reads
    always_comb begin
        size_be = '1;
        case (req_size)
            2'b00:   size_be = NB'(1) << req_off;
            2'b01:   size_be = NB'(3) << req_off;
            default: size_be = '1;
        endcase
        be = req_store ? size_be : '1;
    end

    assign store_lane = req_store_dat << {req_off, 3'b000};
    assign ld_shift   = ld_raw >> {ld_off, 3'b000};

    // Right-justified load data, sign- or zero-extended by the fetch code
    always_comb begin
        ld_ext = ld_shift;
        case (ld_code)
            FC_LB:   ld_ext = DATA_W'($signed(ld_shift[7:0]));
            FC_LBU:  ld_ext = DATA_W'(ld_shift[7:0]);
            FC_LH:   ld_ext = DATA_W'($signed(ld_shift[15:0]));
            FC_LHU:  ld_ext = DATA_W'(ld_shift[15:0]);
            default: ld_ext = ld_shift;
        endcase
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory port, data first, with abort on timeout.
// Latency: strobe one cycle after accept; hit one cycle after mem_ready (2 cycles minimum).
// Backpressure: requests are held by the datapath until the hit pulse; mem_ready stalls up to TIMEOUT cycles.
module mem_request_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                dp_imem_ren,
    input  logic [ADDR_W-1:0]   dp_imem_addr,
    output logic [DATA_W-1:0]   dp_imem_load,
    output logic                dp_i_hit,
    input  logic                dp_dmem_ren,
    input  logic                dp_dmem_wen,
    input  logic [ADDR_W-1:0]   dp_dmem_addr,
    input  logic [DATA_W-1:0]   dp_dmem_store,
    input  logic [2:0]          dp_d_fetch,
    output logic [DATA_W-1:0]   dp_dmem_load,
    output logic                dp_d_hit,
    output logic                dp_d_err,
    output logic                dp_i_err,
    output logic                mem_ren,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_store,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_load,
    input  logic                mem_ready
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [OFF_W-1:0]   lat_off;
    logic [2:0]         lat_code;
    logic               lat_store;

    logic               d_acc, d_bad, i_acc, i_bad, acc_done, acc_abort;
    logic [NB-1:0]      req_be;
    logic [DATA_W-1:0]  req_lane, ld_ext;
    logic [ADDR_W-1:0]  d_word_addr, i_word_addr;

    assign d_word_addr = {dp_dmem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign i_word_addr = {dp_imem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .req_size      (dp_d_fetch[1:0]),
        .req_off       (dp_dmem_addr[OFF_W-1:0]),
        .req_store     (dp_dmem_wen),
        .req_store_dat (dp_dmem_store),
        .be            (req_be),
        .store_lane    (req_lane),
        .ld_code       (lat_code),
        .ld_off        (lat_off),
        .ld_raw        (mem_load),
        .ld_ext        (ld_ext)
    );

    // Arbiter state register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Accept decision in IDLE (data first, never while a hit retires), completion or abort in an access
    always_comb begin
        state_nxt = state;
        d_acc     = 1'b0;
        d_bad     = 1'b0;
        i_acc     = 1'b0;
        i_bad     = 1'b0;
        acc_done  = 1'b0;
        acc_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!dp_i_hit && !dp_d_hit) begin
                    if (dp_dmem_ren || dp_dmem_wen) begin
                        d_acc = 1'b1;
                        if (access_bad(dp_d_fetch, byte_off_t'(dp_dmem_addr[1:0]))) d_bad = 1'b1;
                        else state_nxt = ST_DACC;
                    end else if (dp_imem_ren) begin
                        i_acc = 1'b1;
                        if (dp_imem_addr[1:0] != 2'b00) i_bad = 1'b1;
                        else state_nxt = ST_IACC;
                    end
                end
            end
            ST_DACC, ST_IACC: begin
                if (mem_ready) begin
                    acc_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    acc_abort = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request latching, registered memory strobes, hit/err pulses, load results and the wait counter
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt          <= '0;
            lat_off      <= '0;
            lat_code     <= '0;
            lat_store    <= 1'b0;
            mem_ren      <= 1'b0;
            mem_wen      <= 1'b0;
            mem_addr     <= '0;
            mem_store    <= '0;
            mem_be       <= '0;
            dp_i_hit     <= 1'b0;
            dp_d_hit     <= 1'b0;
            dp_i_err     <= 1'b0;
            dp_d_err     <= 1'b0;
            dp_imem_load <= '0;
            dp_dmem_load <= '0;
        end else begin
            dp_i_hit <= 1'b0;
            dp_d_hit <= 1'b0;
            dp_i_err <= 1'b0;
            dp_d_err <= 1'b0;

            if (d_acc) begin
                lat_off   <= dp_dmem_addr[OFF_W-1:0];
                lat_code  <= dp_d_fetch;
                lat_store <= dp_dmem_wen;
                if (d_bad) begin
                    dp_d_hit <= 1'b1;
                    dp_d_err <= 1'b1;
                end else begin
                    mem_ren   <= ~dp_dmem_wen;
                    mem_wen   <= dp_dmem_wen;
                    mem_addr  <= d_word_addr;
                    mem_be    <= req_be;
                    mem_store <= dp_dmem_wen ? req_lane : '0;
                end
            end

            if (i_acc) begin
                if (i_bad) begin
                    dp_i_hit <= 1'b1;
                    dp_i_err <= 1'b1;
                end else begin
                    mem_ren   <= 1'b1;
                    mem_wen   <= 1'b0;
                    mem_addr  <= i_word_addr;
                    mem_be    <= '1;
                    mem_store <= '0;
                end
            end

            if (acc_done || acc_abort) begin
                mem_ren   <= 1'b0;
                mem_wen   <= 1'b0;
                mem_addr  <= '0;
                mem_be    <= '0;
                mem_store <= '0;
                cnt       <= '0;
                if (state == ST_DACC) begin
                    dp_d_hit <= 1'b1;
                    dp_d_err <= acc_abort;
                    if (acc_done && !lat_store) dp_dmem_load <= ld_ext;
                end else begin
                    dp_i_hit <= 1'b1;
                    dp_i_err <= acc_abort;
                    if (acc_done) dp_imem_load <= mem_load;
                end
            end else if (state != ST_IDLE) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Randomized and directed bench: the bench acts as both datapath and memory controller.
// Latency: expectations are derived per transaction from size, alignment and ready delay.
// Backpressure: mem_ready is delayed by a chosen number of strobe cycles, past TIMEOUT to force aborts.
module tb_mem_request_arbiter;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        nRst;
    logic        dp_imem_ren, dp_dmem_ren, dp_dmem_wen, mem_ready;
    logic [31:0] dp_imem_addr, dp_dmem_addr, dp_dmem_store, mem_load;
    logic [2:0]  dp_d_fetch;
    logic [31:0] dp_imem_load, dp_dmem_load, mem_addr, mem_store;
    logic        dp_i_hit, dp_d_hit, dp_d_err, dp_i_err, mem_ren, mem_wen;
    logic [3:0]  mem_be;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_dload = '0;
    logic [31:0] exp_iload = '0;

    mem_request_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .nRst(nRst),
        .dp_imem_ren(dp_imem_ren), .dp_imem_addr(dp_imem_addr), .dp_imem_load(dp_imem_load),
        .dp_i_hit(dp_i_hit), .dp_dmem_ren(dp_dmem_ren), .dp_dmem_wen(dp_dmem_wen),
        .dp_dmem_addr(dp_dmem_addr), .dp_dmem_store(dp_dmem_store), .dp_d_fetch(dp_d_fetch),
        .dp_dmem_load(dp_dmem_load), .dp_d_hit(dp_d_hit), .dp_d_err(dp_d_err), .dp_i_err(dp_i_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_store(mem_store),
        .mem_be(mem_be), .mem_load(mem_load), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Illegal code, or address not a multiple of the access size in bytes
    function automatic bit data_bad(input logic [2:0] code, input logic [31:0] addr);
        int nb;
        if (!(code inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
        nb = 1 << code[1:0];
        return (addr % nb) != 0;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] code, input logic [31:0] raw);
        case (code)
            3'b000:  return 32'($signed(raw[7:0]));
            3'b001:  return 32'($signed(raw[15:0]));
            3'b100:  return 32'(raw[7:0]);
            3'b101:  return 32'(raw[15:0]);
            default: return raw;
        endcase
    endfunction

    // One transaction, starting in the current post-edge window (cycle 0); ends one idle cycle after the hit
    task automatic run_txn(input bit is_d, input bit wen, input logic [31:0] addr, input logic [31:0] st,
                           input logic [2:0] code, input int dly, input logic [31:0] ld);
        int          off, nb, exp_strobes, exp_hit_cyc, scount;
        bit          bad, exp_err, done;
        logic [3:0]  ebe;
        off     = int'(addr[1:0]);
        bad     = is_d ? data_bad(code, addr) : (off != 0);
        exp_strobes = bad ? 0 : ((dly < TMO) ? dly + 1 : TMO);
        exp_err = bad || (dly >= TMO);
        exp_hit_cyc = bad ? 1 : exp_strobes + 1;
        nb      = 1 << code[1:0];
        ebe     = (is_d && wen) ? 4'(((1 << nb) - 1) << off) : 4'hF;
        if (is_d) begin
            dp_dmem_addr  = addr;
            dp_dmem_store = st;
            dp_d_fetch    = code;
            dp_dmem_wen   = wen;
            dp_dmem_ren   = wen ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
            dp_imem_addr = addr;
            dp_imem_ren  = 1'b1;
        end
        scount = 0;
        done   = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            mem_load  = $urandom;
            chk(is_d ? "no_i_hit_in_data" : "no_d_hit_in_fetch", is_d ? dp_i_hit : dp_d_hit, 0);
            if (mem_ren || mem_wen) begin
                scount++;
                if (scount == 1) chk("first_strobe_cycle", cyc, 1);
                chk("mem_wen", mem_wen, is_d && wen);
                chk("mem_ren", mem_ren, !(is_d && wen));
                chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                chk("mem_be", mem_be, ebe);
                if (is_d && wen) chk("mem_store", mem_store, st << (8 * off));
                if (is_d) begin
                    dp_dmem_addr  = $urandom;
                    dp_dmem_store = $urandom;
                    dp_d_fetch    = 3'($urandom);
                end else begin
                    dp_imem_addr = $urandom;
                end
                if (scount - 1 == dly) begin
                    mem_ready = 1'b1;
                    mem_load  = ld;
                end
            end
            if (is_d ? dp_d_hit : dp_i_hit) begin
                done = 1'b1;
                if (!exp_err) begin
                    if (is_d && !wen) exp_dload = extend(code, ld >> (8 * off));
                    if (!is_d)        exp_iload = ld;
                end
                chk("hit_cycle", cyc, exp_hit_cyc);
                chk("strobe_count", scount, exp_strobes);
                chk("err", is_d ? dp_d_err : dp_i_err, exp_err);
                chk("dmem_load", dp_dmem_load, exp_dload);
                chk("imem_load", dp_imem_load, exp_iload);
                if (is_d) begin
                    dp_dmem_ren = 1'b0;
                    dp_dmem_wen = 1'b0;
                end else begin
                    dp_imem_ren = 1'b0;
                end
                // a ready arriving after an abort must be ignored
                if (exp_err && !bad) mem_ready = 1'b1;
            end
        end
        if (!done) chk("hit_within_budget", 0, 1);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        chk("hit_single_pulse", {30'd0, dp_d_hit, dp_i_hit}, 0);
        chk("no_accept_in_hit_cycle", mem_ren | mem_wen, 0);
        chk("dmem_load_hold", dp_dmem_load, exp_dload);
    endtask

    initial begin
        bit          isd, wen;
        logic [2:0]  code;
        logic [31:0] a;
        int          dly;
        nRst = 1'b0;
        dp_imem_ren = 1'b0; dp_dmem_ren = 1'b0; dp_dmem_wen = 1'b0; mem_ready = 1'b0;
        dp_imem_addr = '0; dp_dmem_addr = '0; dp_dmem_store = '0; dp_d_fetch = '0; mem_load = '0;
        #1;
        chk("rst_strobes", {mem_ren, mem_wen, mem_be}, 0);
        chk("rst_hits", {dp_i_hit, dp_d_hit, dp_i_err, dp_d_err}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_store", mem_store, 0);
        chk("rst_loads", dp_imem_load | dp_dmem_load, 0);
        @(posedge clk);
        #2 nRst = 1'b1;
        @(posedge clk);
        #1;

        run_txn(1, 0, 32'h100, 32'h0, 3'b010, 0, 32'hDEADBEEF);
        chk("lw_result", dp_dmem_load, 32'hDEADBEEF);
        run_txn(1, 0, 32'h103, 32'h0, 3'b000, 1, 32'h80FF_0000);
        chk("lb_result", dp_dmem_load, 32'hFFFFFF80);
        run_txn(1, 0, 32'h103, 32'h0, 3'b100, 2, 32'h80FF_0000);
        chk("lbu_result", dp_dmem_load, 32'h00000080);
        run_txn(1, 1, 32'h102, 32'h1234, 3'b001, 0, 32'h0);
        run_txn(1, 1, 32'h101, 32'h1234, 3'b001, 0, 32'h0);
        run_txn(1, 0, 32'h104, 32'h0, 3'b011, 0, 32'h0);
        run_txn(0, 0, 32'h202, 32'h0, 3'b000, 0, 32'h0);
        run_txn(1, 0, 32'h108, 32'h0, 3'b010, 10, 32'h5555AAAA);
        run_txn(0, 0, 32'h204, 32'h0, 3'b000, 10, 32'h11112222);
        // simultaneous requests: data first, fetch accepted the cycle after the data hit
        dp_imem_addr = 32'h300;
        dp_imem_ren  = 1'b1;
        run_txn(1, 0, 32'h10C, 32'h0, 3'b001, 1, 32'h0000_8001);
        run_txn(0, 0, 32'h300, 32'h0, 3'b000, 0, 32'h00000013);
        chk("fetch_result", dp_imem_load, 32'h00000013);

        for (int i = 0; i < 200; i++) begin
            isd  = $urandom_range(0, 2) != 0;
            wen  = 1'($urandom_range(0, 1));
            code = 3'($urandom_range(0, 7));
            a    = ($urandom & 32'h0000_FFFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            dly  = $urandom_range(0, 5);
            if (isd && $urandom_range(0, 3) == 0) begin
                dp_imem_addr = $urandom & 32'h0000_FFFC;
                dp_imem_ren  = 1'b1;
                run_txn(1, wen, a, $urandom, code, dly, $urandom);
                run_txn(0, 0, dp_imem_addr, 32'h0, 3'b000, $urandom_range(0, 5), $urandom);
            end else begin
                run_txn(isd, wen, a, $urandom, code, dly, $urandom);
            end
        end

        // reset in the middle of a fetch
        dp_imem_addr = 32'h400;
        dp_imem_ren  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("iacc_strobe_on", mem_ren, 1);
        #2 nRst = 1'b0;
        #1;
        chk("async_rst_strobes", {mem_ren, mem_wen, mem_be}, 0);
        chk("async_rst_addr", mem_addr, 0);
        chk("async_rst_loads", dp_imem_load | dp_dmem_load, 0);
        dp_imem_ren = 1'b0;
        exp_dload = '0;
        exp_iload = '0;
        @(posedge clk);
        #2 nRst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            chk("no_hit_after_rst", {30'd0, dp_i_hit, dp_d_hit}, 0);
            chk("no_strobe_after_rst", mem_ren | mem_wen, 0);
        end
        run_txn(0, 0, 32'h500, 32'h0, 3'b000, 0, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
